// File: rtl/dpll_pkg.sv
//------------------------------------------------------------------------------
// dpll_pkg
//   Shared types and defaults for the DPLL sequencing/lock controller.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dpll_pkg;

  // Divider / postscaler widths, matching the DPLL configuration ports
  localparam int M_W = 3;
  localparam int N_W = 2;

  // Configuration applied out of reset
  localparam logic [M_W-1:0] M_RESET_DFLT = 3'd3;
  localparam logic [N_W-1:0] N_RESET_DFLT = 2'd0;

  // Controller states
  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    ACQUIRE    = 2'd1,
    LOCKED     = 2'd2,
    LOS        = 2'd3
  } dpll_state_t;

endpackage

`default_nettype wire

// File: rtl/dpll_ctrl_sync_edge.sv
//------------------------------------------------------------------------------
// sync_edge
//   Two-flop synchroniser for an asynchronous input followed by a registered
//   single-cycle rising-edge pulse.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  // [0],[1] are the synchroniser, [2] holds the previous synchronised value
  logic [2:0] sync_q;

  // Synchronise, then flag a 0->1 transition of the synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      rise   <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpll_ctrl.sv
//------------------------------------------------------------------------------
// dpll_ctrl
//   Configures and resets the mixer DPLL, qualifies lock from phase-detector
//   activity per reference period and detects loss of the reference.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dpll_ctrl
  import dpll_pkg::*;
#(
  parameter int             RST_CYCLES     = 16,
  parameter int             LOS_CYCLES     = 20000,
  parameter int             ERR_MAX        = 8,
  parameter int             LOCK_PERIODS   = 64,
  parameter int             UNLOCK_PERIODS = 4,
  parameter logic [M_W-1:0] M_RESET        = M_RESET_DFLT,
  parameter logic [N_W-1:0] N_RESET        = N_RESET_DFLT
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           cfg_valid,
  input  logic [M_W-1:0] cfg_m,
  input  logic [N_W-1:0] cfg_n,
  output logic           cfg_ready,
  input  logic           sigin,
  input  logic           pd_up,
  input  logic           pd_down,
  output logic           dpll_rstb,
  output logic [M_W-1:0] m,
  output logic [N_W-1:0] n,
  output logic           locked,
  output logic           los
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int LOS_W  = $clog2(LOS_CYCLES + 1);
  localparam int ERR_W  = $clog2(ERR_MAX + 2);
  localparam int GOOD_W = $clog2(LOCK_PERIODS + 1);
  localparam int BAD_W  = $clog2(UNLOCK_PERIODS + 1);

  dpll_state_t       state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LOS_W-1:0]  los_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [BAD_W-1:0]  bad_cnt, bad_nxt;
  logic              sig_edge;
  logic              pd_active;
  logic              accept;
  logic              good_period;
  logic              timeout;
  logic              rstb_d, ready_d, locked_d, los_d;

  sync_edge u_sync_edge (
    .clk      (CLK),
    .rst      (RST),
    .async_in (sigin),
    .rise     (sig_edge)
  );

  assign pd_active   = pd_up | pd_down;
  assign accept      = cfg_valid & cfg_ready;
  assign good_period = (err_cnt <= ERR_W'(ERR_MAX));
  assign timeout     = (los_cnt == LOS_W'(LOS_CYCLES));

  // State register plus outputs registered from the next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RESET_HOLD;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      dpll_rstb <= 1'b0;
      cfg_ready <= 1'b0;
      locked    <= 1'b0;
      los       <= 1'b0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      dpll_rstb <= rstb_d;
      cfg_ready <= ready_d;
      locked    <= locked_d;
      los       <= los_d;
    end
  end

  // Next state and period run-length counters; accept > edge > timeout
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    case (state)
      RESET_HOLD: begin
        good_nxt = '0;
        bad_nxt  = '0;
        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) state_nxt = ACQUIRE;
      end
      ACQUIRE: begin
        bad_nxt = '0;
        if (sig_edge) begin
          if (!good_period) begin
            good_nxt = '0;
          end else if (good_cnt == GOOD_W'(LOCK_PERIODS - 1)) begin
            good_nxt  = '0;
            state_nxt = LOCKED;
          end else begin
            good_nxt = good_cnt + 1'b1;
          end
        end else if (timeout) begin
          state_nxt = LOS;
        end
      end
      LOCKED: begin
        good_nxt = '0;
        if (sig_edge) begin
          if (good_period) begin
            bad_nxt = '0;
          end else if (bad_cnt == BAD_W'(UNLOCK_PERIODS - 1)) begin
            bad_nxt   = '0;
            state_nxt = ACQUIRE;
          end else begin
            bad_nxt = bad_cnt + 1'b1;
          end
        end else if (timeout) begin
          state_nxt = LOS;
        end
      end
      LOS: begin
        if (sig_edge) state_nxt = RESET_HOLD;
      end
      default: state_nxt = RESET_HOLD;
    endcase
    if (accept) state_nxt = RESET_HOLD;
  end

  // Output decode of the state being entered
  always_comb begin
    rstb_d   = 1'b0;
    ready_d  = 1'b0;
    locked_d = 1'b0;
    los_d    = 1'b0;
    case (state_nxt)
      ACQUIRE: begin
        rstb_d  = 1'b1;
        ready_d = 1'b1;
      end
      LOCKED: begin
        rstb_d   = 1'b1;
        ready_d  = 1'b1;
        locked_d = 1'b1;
      end
      LOS: begin
        ready_d = 1'b1;
        los_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset-hold duration counter, idle at zero outside RESET_HOLD
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     hold_cnt <= '0;
    else if (state == RESET_HOLD) hold_cnt <= hold_cnt + 1'b1;
    else                         hold_cnt <= '0;
  end

  // Phase-detector activity per period; the edge cycle starts the new period
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                       err_cnt <= '0;
    else if (state == RESET_HOLD)                  err_cnt <= '0;
    else if (sig_edge)                             err_cnt <= ERR_W'(pd_active);
    else if (pd_active && err_cnt != ERR_W'(ERR_MAX + 1)) err_cnt <= err_cnt + 1'b1;
  end

  // Cycles since the last reference edge, saturating at the timeout value
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      los_cnt <= '0;
    else if (state == RESET_HOLD) los_cnt <= '0;
    else if (sig_edge)            los_cnt <= '0;
    else if (!timeout)            los_cnt <= los_cnt + 1'b1;
  end

  // Divider configuration changes only on an accepted request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m <= M_RESET;
      n <= N_RESET;
    end else if (accept) begin
      m <= cfg_m;
      n <= cfg_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dpll_ctrl.sv
//------------------------------------------------------------------------------
// tb_dpll_ctrl
//   Self-checking bench for dpll_ctrl: a period-level behavioural model checked
//   every cycle, plus directed checks with hand-derived values.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dpll_ctrl;

  localparam int RST_CYCLES     = 16;
  localparam int LOS_CYCLES     = 2000;
  localparam int ERR_MAX        = 8;
  localparam int LOCK_PERIODS   = 64;
  localparam int UNLOCK_PERIODS = 4;
  localparam int PER            = 100;
  localparam int MD_HOLD = 0, MD_ACQ = 1, MD_LOCK = 2, MD_LOS = 3;

  logic       clk, rst;
  logic       cfg_valid;
  logic [2:0] cfg_m;
  logic [1:0] cfg_n;
  logic       cfg_ready;
  logic       sigin, pd_up, pd_down;
  logic       dpll_rstb;
  logic [2:0] m;
  logic [1:0] n;
  logic       locked, los;

  int checks   = 0;
  int failures = 0;

  dpll_ctrl #(
    .RST_CYCLES     (RST_CYCLES),
    .LOS_CYCLES     (LOS_CYCLES),
    .ERR_MAX        (ERR_MAX),
    .LOCK_PERIODS   (LOCK_PERIODS),
    .UNLOCK_PERIODS (UNLOCK_PERIODS)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .cfg_valid (cfg_valid),
    .cfg_m     (cfg_m),
    .cfg_n     (cfg_n),
    .cfg_ready (cfg_ready),
    .sigin     (sigin),
    .pd_up     (pd_up),
    .pd_down   (pd_down),
    .dpll_rstb (dpll_rstb),
    .m         (m),
    .n         (n),
    .locked    (locked),
    .los       (los)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         md, hold_left, err, silent, good_run, bad_run;
  logic [3:0] samp;
  logic [2:0] exp_m;
  logic [1:0] exp_n;
  logic       mdl_edge;
  int         pd;

  // reference rise as seen by the sequencer: sampled 3 clock edges earlier
  assign mdl_edge = samp[2] & ~samp[3];
  assign pd       = (pd_up | pd_down) ? 1 : 0;

  // Mode-level model of the controller
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md <= MD_HOLD; hold_left <= RST_CYCLES; err <= 0; silent <= 0;
      good_run <= 0; bad_run <= 0; samp <= '0; exp_m <= 3'd3; exp_n <= 2'd0;
    end else begin
      samp <= {samp[2:0], sigin};
      if (md == MD_HOLD) begin
        err <= 0; silent <= 0; good_run <= 0; bad_run <= 0;
      end else if (mdl_edge) begin
        err <= pd; silent <= 0;
      end else begin
        err <= err + pd; silent <= silent + 1;
      end
      if (cfg_valid && md != MD_HOLD) begin
        exp_m <= cfg_m; exp_n <= cfg_n; md <= MD_HOLD; hold_left <= RST_CYCLES;
      end else begin
        case (md)
          MD_HOLD: if (hold_left == 1) md <= MD_ACQ; else hold_left <= hold_left - 1;
          MD_ACQ:
            if (mdl_edge) begin
              if (err > ERR_MAX) good_run <= 0;
              else if (good_run + 1 == LOCK_PERIODS) begin md <= MD_LOCK; good_run <= 0; end
              else good_run <= good_run + 1;
            end else if (silent >= LOS_CYCLES) md <= MD_LOS;
          MD_LOCK:
            if (mdl_edge) begin
              if (err <= ERR_MAX) bad_run <= 0;
              else if (bad_run + 1 == UNLOCK_PERIODS) begin md <= MD_ACQ; bad_run <= 0; end
              else bad_run <= bad_run + 1;
            end else if (silent >= LOS_CYCLES) md <= MD_LOS;
          default:
            if (mdl_edge) begin md <= MD_HOLD; hold_left <= RST_CYCLES; end
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (dpll_rstb !== (md == MD_ACQ || md == MD_LOCK) || cfg_ready !== (md != MD_HOLD) ||
          locked !== (md == MD_LOCK) || los !== (md == MD_LOS) || m !== exp_m || n !== exp_n) begin
        failures++;
        $display("FAIL model t=%0t: got rstb=%b rdy=%b lk=%b los=%b m=%0d n=%0d, want mode=%0d m=%0d n=%0d",
                 $time, dpll_rstb, cfg_ready, locked, los, m, n, md, exp_m, exp_n);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // one reference period: high half then low half, with a pd pulse of w cycles
  task automatic period(input int w, input bit use_down);
    for (int i = 0; i < PER; i++) begin
      sigin   = (i < PER / 2);
      pd_up   = !use_down && (i >= 20) && (i < 20 + w);
      pd_down =  use_down && (i >= 20) && (i < 20 + w);
      @(negedge clk);
    end
    pd_up = 1'b0; pd_down = 1'b0;
  endtask

  // negedges until o_sig reaches val (bounded)
  task automatic count_until(input bit want, input int which, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((which == 0) ? dpll_rstb : los) !== want && k < 5000);
  endtask

  initial begin
    int k;
    rst = 1'b1; cfg_valid = 1'b0; cfg_m = '0; cfg_n = '0;
    sigin = 1'b0; pd_up = 1'b0; pd_down = 1'b0;
    #12;
    chk("reset_rstb", dpll_rstb, 0);
    chk("reset_m", m, 3);
    chk("reset_n", n, 0);
    chk("reset_ready", cfg_ready, 0);
    chk("reset_locked", locked, 0);
    chk("reset_los", los, 0);
    @(negedge clk); rst = 1'b0;

    // no reference: hold, acquire, then loss of signal
    count_until(1'b1, 0, k);
    chk("hold_after_reset", k, 16);
    count_until(1'b1, 1, k);
    chk("los_delay", k, LOS_CYCLES + 1);
    chk("los_rstb_low", dpll_rstb, 0);

    // recovery edge
    sigin = 1'b1;
    count_until(1'b0, 1, k);
    chk("los_fall_delay", k, 4);
    count_until(1'b1, 0, k);
    chk("recover_hold", k, 16);
    sigin = 1'b0;
    tick(10);

    // lock qualification
    repeat (LOCK_PERIODS - 1) period(4, 1'b0);
    chk("not_locked_63", locked, 0);
    period(4, 1'b0);
    chk("locked_64", locked, 1);

    // wide pulses drop lock on the 4th bad edge
    repeat (UNLOCK_PERIODS) period(20, 1'b0);
    chk("still_locked_3bad", locked, 1);
    period(4, 1'b0);
    chk("unlocked_4bad", locked, 0);
    repeat (LOCK_PERIODS) period(4, 1'b0);
    chk("relocked", locked, 1);

    // alternating bad/good never accumulates
    repeat (8) begin
      period(20, 1'b1);
      period(4, 1'b0);
    end
    chk("alt_locked", locked, 1);

    // reconfiguration while locked
    chk("ready_locked", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_m = 3'd5; cfg_n = 2'd2;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_ready_fall", cfg_ready, 0);
    chk("cfg_m", m, 5);
    chk("cfg_n", n, 2);
    chk("cfg_locked_fall", locked, 0);
    chk("cfg_rstb_fall", dpll_rstb, 0);
    count_until(1'b1, 0, k);
    chk("cfg_hold_len", k, 16);

    // config coinciding with timeout wins
    k = 0;
    while (!(md == MD_ACQ && silent == LOS_CYCLES) && k < 5000) begin @(negedge clk); k++; end
    chk("reach_timeout", (k < 5000), 1);
    cfg_valid = 1'b1; cfg_m = 3'd2; cfg_n = 2'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("coinc_cfg_los", los, 0);
    chk("coinc_cfg_m", m, 2);
    chk("coinc_cfg_rstb", dpll_rstb, 0);
    count_until(1'b1, 0, k);
    chk("coinc_cfg_hold", k, 16);

    // edge coinciding with timeout suppresses loss of signal
    k = 0;
    while (!(md == MD_ACQ && silent == LOS_CYCLES - 3) && k < 5000) begin @(negedge clk); k++; end
    chk("reach_pre_timeout", (k < 5000), 1);
    sigin = 1'b1;
    tick(12);
    chk("coinc_edge_los", los, 0);
    chk("coinc_edge_rstb", dpll_rstb, 1);

    // asynchronous reset mid-acquire
    #2 rst = 1'b1;
    #1;
    chk("arst_rstb", dpll_rstb, 0);
    chk("arst_m", m, 3);
    chk("arst_n", n, 0);
    chk("arst_ready", cfg_ready, 0);
    chk("arst_los", los, 0);
    @(negedge clk); rst = 1'b0;
    tick(20);
    chk("arst_hold_done", dpll_rstb, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dpll_ctrl.md
# dpll_ctrl

Sequencing and lock-supervision controller for the mixer's digital PLL. It owns the DPLL's divider (`m`) and postscaler (`n`) configuration and its reset. It accepts new settings over a valid/ready handshake and holds the DPLL in reset while settings change. It qualifies lock from the phase-detector activity in each input period and detects loss of the reference signal. It sits between the control-register block and the DPLL instance; the DPLL exports its phase-detector `up`/`down` flags for this block's use.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `dpll_rstb` is held low after any (re)configuration.
- `LOS_CYCLES`, 20000: cycles without a `sigin` rising edge before loss of signal (about 7 periods at 35 kHz from 100 MHz).
- `ERR_MAX`, 8: maximum phase-detector-active cycles per input period for a "good" period.
- `LOCK_PERIODS`, 64: consecutive good periods needed to declare lock.
- `UNLOCK_PERIODS`, 4: consecutive bad periods needed to drop lock.
- `M_RESET`, 3'd3 / `N_RESET`, 2'd0: configuration applied out of reset.

Ports:
- `CLK` in 1: 100 MHz system clock.
- `RST` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: new configuration offered.
- `cfg_m` in 3: requested feedback divider.
- `cfg_n` in 2: requested postscaler.
- `cfg_ready` out 1: configuration can be accepted this cycle.
- `sigin` in 1: asynchronous reference input (same net as the DPLL input).
- `pd_up` in 1: DPLL phase-detector up flag.
- `pd_down` in 1: DPLL phase-detector down flag.
- `dpll_rstb` out 1: active-low reset to the DPLL.
- `m` out 3: divider to the DPLL.
- `n` out 2: postscaler to the DPLL.
- `locked` out 1: DPLL qualified as locked.
- `los` out 1: reference lost.

## Operation
- `sigin` passes through a 2-FF synchroniser, then a rising-edge detect (`edge`).
- `err_cnt` counts cycles with `pd_up|pd_down` high, saturating at `ERR_MAX+1`. On `edge` the period is good if `err_cnt <= ERR_MAX`; `err_cnt` then clears (the edge cycle's own activity is counted into the new period).
- `los_cnt` increments every cycle and clears on `edge`; it saturates at `LOS_CYCLES`.
- States:
  - RESET_HOLD: `dpll_rstb`=0 for `RST_CYCLES` cycles, then go to ACQUIRE. `good_cnt`, `bad_cnt`, `err_cnt` and `los_cnt` are cleared.
  - ACQUIRE: a good period increments `good_cnt`; a bad period clears it. When `good_cnt` reaches `LOCK_PERIODS`, go to LOCKED.
  - LOCKED: `locked`=1. A bad period increments `bad_cnt`; a good period clears it. When `bad_cnt` reaches `UNLOCK_PERIODS`, go to ACQUIRE with `good_cnt` at 0.
  - LOS: `dpll_rstb`=0 and `los`=1. The first `edge` goes to RESET_HOLD.
- From ACQUIRE or LOCKED, `los_cnt == LOS_CYCLES` goes to LOS.
- `cfg_ready`=1 in ACQUIRE, LOCKED and LOS. On `cfg_valid & cfg_ready`, `cfg_m`/`cfg_n` are latched into `m`/`n` and the FSM goes to RESET_HOLD.
- Priority when events coincide: config accept, then `edge`, then LOS timeout. An edge in the same cycle as the timeout clears the timer and does not trigger LOS.
- `m` and `n` change only on config accept or reset, so they are always stable while `dpll_rstb`=1.

## Timing
- Reset values: FSM=RESET_HOLD, `dpll_rstb`=0, `m`=`M_RESET`, `n`=`N_RESET`, `cfg_ready`=0, `locked`=0, `los`=0.
- All outputs are registered.
- `sigin` to `edge` latency is 3 cycles.
- Config accept at cycle T:
  - `m`/`n` update and `cfg_ready`, `dpll_rstb` and `locked` fall at T+1.
  - `dpll_rstb` rises at T+1+`RST_CYCLES`.
- `locked` rises 1 cycle after the `LOCK_PERIODS`-th consecutive good edge, and falls 1 cycle after the `UNLOCK_PERIODS`-th consecutive bad edge.
- `los` and `dpll_rstb` low assert 1 cycle after the timeout. `los` falls 1 cycle after the recovery edge.
- `RST` asserted mid-operation immediately forces the reset values, including any in-flight handshake, which is dropped.

## Structure
- `dpll_pkg`: the state enum (RESET_HOLD, ACQUIRE, LOCKED, LOS), the `M_RESET`/`N_RESET` defaults, and the `m`/`n` widths shared with the DPLL.
- Sub-module `sync_edge`: 2-FF synchroniser plus rising-edge pulse, with asynchronous active-high reset.

## Test plan
- Reset release with no `sigin`: `dpll_rstb` goes high after 16 cycles, then `los`=1 and `dpll_rstb`=0 20000 cycles later. A 40 kHz `sigin` gives `los`=0 and `dpll_rstb` high again 16 cycles after the edge is seen.
- 40 kHz `sigin` with `pd_up` pulses of 4 cycles per period: `locked`=1 one cycle after the 64th edge. Widening the pulses to 20 cycles gives `locked`=0 after the 4th wide period.
- Alternating good and bad periods while LOCKED: `locked` stays 1 because `bad_cnt` never reaches 4.
- Config `cfg_m`=5, `cfg_n`=2 while LOCKED: `cfg_ready`=0, `m`=5, `n`=2 and `locked`=0 at T+1, with `dpll_rstb` low for exactly 16 cycles.
- Coincidences:
  - `cfg_valid` in the same cycle as the LOS timeout: the config is accepted and the FSM goes to RESET_HOLD, not LOS.
  - `edge` in the same cycle as the timeout: no LOS.
- Async `RST` pulse mid-ACQUIRE: all outputs return to their reset values within the same cycle and `m` returns to 3.
